// File: rtl/note_sequencer.sv
// Note sequencer: queues note commands and plays them through clkgen.
// Drives maxval, a per-note clkgen reset, an audible gate and a done pulse.
module note_sequencer #(
  parameter int N         = 16,
  parameter int DW        = 16,
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_UNITS = 0
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     note_valid_i,
  output logic                     note_ready_o,
  input  logic [N-1:0]             note_period_i,
  input  logic [DW-1:0]            note_dur_i,
  input  logic                     note_rest_i,
  output logic [N-1:0]             maxval_o,
  output logic                     clkgen_rst_o,
  output logic                     gate_o,
  output logic                     done_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] GAPW = DW'(GAP_UNITS);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [N-1:0]  period;
    logic [DW-1:0] dur;
    logic          rest;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  note_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_rem;
  logic [N-1:0]  r_maxval;
  logic          r_gate;
  logic          r_done;

  logic  w_push;
  logic  w_pop;
  logic  w_empty;
  logic  w_wrap;
  logic  w_last;
  note_t w_head;

  assign w_empty      = (r_cnt == '0);
  assign note_ready_o = (r_cnt != FULL) && !flush_i;
  assign w_push       = note_valid_i && note_ready_o;
  assign w_pop        = (r_state == S_LOAD) && !flush_i;
  assign w_head       = r_mem[r_rd];
  assign w_wrap       = (r_pre == PMAX);
  assign w_last       = w_wrap && (r_rem <= DW'(1));

  assign maxval_o     = r_maxval;
  assign gate_o       = r_gate;
  assign done_o       = r_done;
  assign clkgen_rst_o = (r_state == S_LOAD);
  assign busy_o       = (r_state != S_IDLE) || !w_empty;
  assign level_o      = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr] <= {note_period_i, note_dur_i, note_rest_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (!w_empty) w_next = S_LOAD;
        S_LOAD: w_next = (w_head.dur == '0) ? S_IDLE : S_PLAY;
        S_PLAY: begin
          if (w_last) begin
            if (GAP_UNITS > 0) w_next = S_GAP;
            else w_next = w_empty ? S_IDLE : S_LOAD;
          end
        end
        S_GAP: if (w_last) w_next = w_empty ? S_IDLE : S_LOAD;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Prescaled unit countdown shared by PLAY and GAP
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_maxval <= '0;
      r_gate   <= 1'b0;
      r_done   <= 1'b0;
      r_pre    <= '0;
      r_rem    <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_gate <= 1'b0;
        r_pre  <= '0;
        r_rem  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: r_gate <= 1'b0;
          S_LOAD: begin
            if (w_head.dur == '0) begin
              r_done <= 1'b1;
            end else begin
              r_maxval <= w_head.period;
              r_gate   <= !w_head.rest;
              r_rem    <= w_head.dur;
              r_pre    <= '0;
            end
          end
          S_PLAY, S_GAP: begin
            if (w_wrap) begin
              r_pre <= '0;
              if (r_rem != '0) r_rem <= r_rem - DW'(1);
            end else begin
              r_pre <= r_pre + PW'(1);
            end
            if (w_last && r_state == S_PLAY) begin
              r_gate <= 1'b0;
              r_done <= 1'b1;
              if (GAP_UNITS > 0) r_rem <= GAPW;
            end
          end
          default: r_gate <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Upstream control stage for clkgen. Buffers note commands (half-period count, duration, rest flag) in a small FIFO and plays them in order. For each note it drives clkgen's maxval, resets clkgen so every note starts in a known phase, and raises a gate that downstream waveform/output stages use for muting. It times each note with a prescaled unit tick.

Parameters:
N, 16, width of note_period_i / maxval_o; matches clkgen N
DW, 16, width of note_dur_i (duration in units)
DEPTH, 8, FIFO depth in entries; power of 2, >= 2
TICK_DIV, 50000, clk_i cycles per duration unit (1 ms at 50 MHz); >= 1
GAP_UNITS, 0, silent units inserted after every note; 0 = no gap state

Ports:
clk_i  input  1  clock
reset  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous: empty FIFO, abort current note
note_valid_i  input  1  note command valid
note_ready_o  output  1  FIFO can accept; equals !full && !flush_i
note_period_i  input  N  maxval value for clkgen for this note
note_dur_i  input  DW  note length in units
note_rest_i  input  1  1 = silent note (gate stays low)
maxval_o  output  N  to clkgen maxval
clkgen_rst_o  output  1  to clkgen reset; high exactly during LOAD
gate_o  output  1  1 = tone audible
done_o  output  1  one-cycle pulse when a note finishes (PLAY or zero-duration LOAD)
busy_o  output  1  state != IDLE or FIFO non-empty
level_o  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset, async: FIFO empty; state IDLE; maxval_o=0; gate_o=0; done_o=0; prescaler and unit counter 0. level_o=0, busy_o=0, clkgen_rst_o=0 (decoded from state).
- Push on the rising edge where note_valid_i && note_ready_o. Pop only in LOAD. When full, a push and a pop cannot coincide because ready is low. Push into a non-full FIFO concurrent with a pop: level unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE: gate_o=0. Go to LOAD if FIFO non-empty.
- LOAD, one cycle:
  - clkgen_rst_o=1; pop the head entry.
  - If dur==0: pulse done_o next cycle, maxval_o unchanged, go to IDLE.
  - Else at the exit edge: maxval_o<=period, gate_o<=!rest, remaining<=dur, prescaler<=0, go to PLAY.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1 and wraps. Each wrap decrements remaining.
  - On the wrap that brings remaining to 0: gate_o<=0, done_o pulses the following cycle.
  - Next state: GAP if GAP_UNITS>0; else LOAD if FIFO non-empty; else IDLE.
  - PLAY lasts exactly dur*TICK_DIV cycles.
- GAP: gate_o=0. Lasts GAP_UNITS*TICK_DIV cycles, then LOAD if FIFO non-empty, else IDLE.
- Latency: acceptance edge E0 -> LOAD during cycle after E1 -> gate_o/maxval_o updated at E2.
- Back-to-back notes with GAP_UNITS=0: gate_o is low for exactly one cycle (the LOAD cycle) between notes.
- maxval_o holds its last value in IDLE/GAP and after flush.
- flush_i (synchronous, highest priority):
  - Next edge: FIFO emptied, state IDLE, gate_o=0, prescaler/remaining cleared, no done_o.
  - Any simultaneous push is dropped (ready low).
- Counter widths: prescaler clog2(TICK_DIV) bits (min 1); remaining DW bits, never underflows.
- reset asserted mid-note: outputs return to reset values immediately (asynchronous).

Test Plan:
- TICK_DIV=4, GAP_UNITS=0: push {period=10, dur=3, rest=0} into empty FIFO at E0 -> clkgen_rst_o high during cycle E1..E2; at E2 maxval_o=10, gate_o=1; gate_o falls at E14; done_o high E14..E15; state IDLE; busy_o=0.
- Push 3 notes back-to-back (dur=2,1,2; periods 5,7,9) -> maxval_o sequence 5,7,9; gate_o high 8, 4, 8 cycles, each separated by a single low LOAD cycle; 3 done_o pulses.
- DEPTH=8: push 9 notes while the first plays, valid held high -> ninth push stalls (note_ready_o=0, level_o=8 after 8 writes); after the first pop, ninth accepted; no entry lost or duplicated.
- {dur=0} then {period=3, dur=1, rest=1}, GAP_UNITS=2 -> done_o for dur=0 with gate_o never high; rest note: maxval_o=3, gate_o stays 0 for 4 cycles, then 8-cycle GAP, then IDLE.
- flush_i mid-PLAY with 4 queued and note_valid_i high -> next edge: level_o=0, gate_o=0, IDLE, no done_o; push that cycle dropped; maxval_o unchanged.
- Assert reset asynchronously mid-PLAY -> gate_o, maxval_o, level_o are 0 before the next clk_i edge; after release, a new note plays normally.
